// File: rtl/pulse_meter.sv
// pulse_meter: synchronizes sig_in and measures period / high time between rising edges,
// presenting each result on a valid/ready port. Define PULSE_METER_FILTER_EN for a 3-sample glitch filter.
module pulse_meter #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sig_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic                 overflow,
  output logic                 missed
);

  localparam int unsigned          MSB     = SYNC_STAGES - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_c;
  logic                   prev_q;
  logic                   rise_c;
  logic [CNT_WIDTH-1:0]   cnt_p_q;
  logic [CNT_WIDTH-1:0]   cnt_h_q;
  logic                   drop_q;
  logic                   cap_c;
  logic                   cap_ovf_c;
  logic                   load_c;

  // Input synchronizer; sync_q[MSB] is the oldest sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

`ifdef PULSE_METER_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Level follows the synchronizer only once three consecutive samples agree.
  always_comb begin
    level_c = filt_q;
    if (sync_q[MSB] && (&hist_q)) begin
      level_c = 1'b1;
    end else if (!sync_q[MSB] && !(|hist_q)) begin
      level_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[MSB]};
      filt_q <= level_c;
    end
  end
`else
  assign level_c = sync_q[MSB];
`endif

  assign rise_c = level_c & ~prev_q;

  // A closing edge wins over saturation in the same cycle.
  always_comb begin
    cap_c     = 1'b0;
    cap_ovf_c = 1'b0;
    if (en && (state_q == MEAS)) begin
      if (rise_c) begin
        cap_c = 1'b1;
      end else if (cnt_p_q == CNT_MAX) begin
        cap_c     = 1'b1;
        cap_ovf_c = 1'b1;
      end
    end
  end

  assign load_c = cap_c & (~m_valid | m_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      cnt_p_q <= '0;
      cnt_h_q <= '0;
    end else begin
      prev_q <= level_c;
      case (state_q)
        IDLE: begin
          if (en) state_q <= ARM;
        end
        ARM: begin
          if (rise_c) begin
            cnt_p_q <= CNT_ONE;
            cnt_h_q <= CNT_ONE;
            state_q <= MEAS;
          end
        end
        MEAS: begin
          if (rise_c) begin
            cnt_p_q <= CNT_ONE;
            cnt_h_q <= CNT_ONE;
          end else if (cnt_p_q == CNT_MAX) begin
            cnt_p_q <= '0;
            cnt_h_q <= '0;
            state_q <= ARM;
          end else begin
            cnt_p_q <= cnt_p_q + CNT_ONE;
            if (level_c) cnt_h_q <= cnt_h_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (!en) begin
        state_q <= IDLE;
        cnt_p_q <= '0;
        cnt_h_q <= '0;
      end
    end
  end

  // Result register: a capture that cannot be loaded is dropped and flagged on the next result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid    <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
      overflow   <= 1'b0;
      missed     <= 1'b0;
      drop_q     <= 1'b0;
    end else if (load_c) begin
      m_valid    <= 1'b1;
      period_cnt <= cnt_p_q;
      high_cnt   <= cnt_h_q;
      overflow   <= cap_ovf_c;
      missed     <= drop_q;
      drop_q     <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (cap_c) drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: randomized waveforms scored against an edge-timestamp model,
// on a 16-bit and a 4-bit counter instance sharing the same stimulus.
module tb_pulse_meter;

  localparam int unsigned SS  = 2;
  localparam int          LAT = SS + 1;

  typedef struct {
    int p;
    int h;
    bit o;
    bit m;
    int cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig_in = 1'b0;
  logic        m_ready = 1'b1;
  logic        v16, o16, ms16, v4, o4, ms4;
  logic [15:0] p16, h16;
  logic [3:0]  p4, h4;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   sig_log[$];
  bit   en_log[$];
  res_t got16[$];
  res_t got4[$];
  res_t exp_q[$];
  bit   st16, st4;
  res_t hd16, hd4;

  always #5 clk = ~clk;

  pulse_meter #(.CNT_WIDTH(16), .SYNC_STAGES(SS)) u_dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .m_valid(v16), .m_ready(m_ready), .period_cnt(p16), .high_cnt(h16),
    .overflow(o16), .missed(ms16)
  );

  pulse_meter #(.CNT_WIDTH(4), .SYNC_STAGES(SS)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .m_valid(v4), .m_ready(m_ready), .period_cnt(p4), .high_cnt(h4),
    .overflow(o4), .missed(ms4)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monitor: collect accepted results and verify outputs stay frozen under backpressure.
  always @(negedge clk) begin
    if (!rst) begin
      st16 = 1'b0;
      st4  = 1'b0;
    end else begin
      if (st16) begin
        check("hold16_valid", v16, 1);
        check("hold16_period", p16, hd16.p);
        check("hold16_high", h16, hd16.h);
        check("hold16_flags", {o16, ms16}, {hd16.o, hd16.m});
      end
      if (st4) begin
        check("hold4_valid", v4, 1);
        check("hold4_period", p4, hd4.p);
        check("hold4_high", h4, hd4.h);
        check("hold4_flags", {o4, ms4}, {hd4.o, hd4.m});
      end
      hd16 = '{int'(p16), int'(h16), o16, ms16, cyc};
      hd4  = '{int'(p4), int'(h4), o4, ms4, cyc};
      st16 = v16 && !m_ready;
      st4  = v4 && !m_ready;
      if (v16 && m_ready) got16.push_back(hd16);
      if (v4 && m_ready) got4.push_back(hd4);
    end
  end

  task automatic step(input bit s);
    sig_in = s;
    if (rdy_mode == 0) m_ready = 1'b1;
    else if (rdy_mode == 1) m_ready = 1'b0;
    else m_ready = 1'($urandom_range(0, 1));
    sig_log.push_back(s);
    en_log.push_back(en);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end
  endtask

  task automatic start_phase();
    rst = 1'b0;
    en = 1'b1;
    rdy_mode = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sig_in = k[0];
      @(posedge clk);
      #1;
      check("rst_valid16", v16, 0);
      check("rst_period16", p16, 0);
      check("rst_high16", h16, 0);
      check("rst_flags16", {o16, ms16}, 0);
      check("rst_valid4", v4, 0);
      check("rst_period4", p4, 0);
    end
    sig_in = 1'b0;
    sig_log.delete();
    en_log.delete();
    got16.delete();
    got4.delete();
    cyc = 0;
    rst = 1'b1;
  endtask

  // Reference: results from rising-edge timestamps of the (optionally filtered) level.
  task automatic build_exp(input int maxv);
    int n;
    int start;
    bit lvl;
    bit e;
    bit f[$];
    int ps[$];
    n = sig_log.size();
    exp_q.delete();
    lvl = 1'b0;
    ps.push_back(0);
    for (int i = 0; i < n; i++) begin
`ifdef PULSE_METER_FILTER_EN
      if (i >= 2 && sig_log[i] == sig_log[i-1] && sig_log[i-1] == sig_log[i-2]) lvl = sig_log[i];
`else
      lvl = sig_log[i];
`endif
      f.push_back(lvl);
      ps.push_back(ps[i] + int'(lvl));
    end
    start = -1;
    for (int i = 0; i < n; i++) begin
      e = f[i] && (i == 0 || !f[i-1]);
      if (!en_log[i]) begin
        start = -1;
      end else if (start < 0) begin
        if (e) start = i;
      end else if (e) begin
        exp_q.push_back('{i - start, ps[i] - ps[start], 1'b0, 1'b0, i});
        start = i;
      end else if (i - start == maxv) begin
        exp_q.push_back('{maxv, ps[i] - ps[start], 1'b1, 1'b0, i});
        start = -1;
      end
    end
  endtask

  function automatic bit same(input res_t a, input res_t b);
    return a.p == b.p && a.h == b.h && a.o == b.o;
  endfunction

  task automatic score(input string tag, input res_t g[$]);
    int nx;
    int j;
    nx = 0;
    foreach (g[k]) begin
      j = -1;
      if (!g[k].m) begin
        if (nx < exp_q.size()) j = nx;
      end else begin
        for (int c = nx + 1; c < exp_q.size(); c++)
          if (same(g[k], exp_q[c]) && exp_q[c].cyc + LAT <= g[k].cyc) j = c;
      end
      check({tag, "_match"}, j >= 0, 1);
      if (j < 0) break;
      check({tag, "_period"}, g[k].p, exp_q[j].p);
      check({tag, "_high"}, g[k].h, exp_q[j].h);
      check({tag, "_ovf"}, g[k].o, exp_q[j].o);
      nx = j + 1;
    end
    check({tag, "_count"}, nx, exp_q.size());
  endtask

  task automatic end_phase(input string tag);
    rdy_mode = 0;
    repeat (40) step(1'b0);
    build_exp(65535);
    score({tag, "16"}, got16);
    build_exp(15);
    score({tag, "4"}, got4);
  endtask

  initial begin
    int idx;
    int hi;
    int lo;

    // Reset hold, single edge, then periodic 3-high / 5-low.
    start_phase();
    repeat (4) step(1'b0);
    wave(3, 5, 1);
    check("one_edge_valid", v16, 0);
    check("one_edge_results", got16.size(), 0);
    wave(3, 5, 10);
    end_phase("periodic");
    check("periodic_results", got16.size(), 10);
    for (int k = 1; k < got16.size(); k++) begin
      check("periodic_spacing", got16[k].cyc - got16[k-1].cyc, 8);
      check("periodic_value", {got16[k].p, got16[k].h, got16[k].o, got16[k].m}, {32'd8, 32'd3, 2'b00});
    end

    // Backpressure for 30 cycles on the same waveform.
    start_phase();
    repeat (4) step(1'b0);
    wave(3, 5, 4);
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) step((k % 8) < 3);
    rdy_mode = 0;
    idx = got16.size();
    for (int k = 30; k < 78; k++) step((k % 8) < 3);
    end_phase("backpressure");
    check("bp_results", got16.size() >= idx + 3, 1);
    if (got16.size() >= idx + 3) begin
      check("bp_held_missed", got16[idx].m, 0);
      check("bp_next_missed", got16[idx+1].m, 1);
      check("bp_after_missed", got16[idx+2].m, 0);
    end

    // One edge then held high: the 4-bit instance saturates once.
    start_phase();
    repeat (5) step(1'b0);
    repeat (40) step(1'b1);
    end_phase("saturate");
    check("sat_results4", got4.size(), 1);
    if (got4.size() == 1)
      check("sat_value4", {got4[0].p, got4[0].h, got4[0].o}, {32'd15, 32'd15, 1'b1});
    check("sat_results16", got16.size(), 0);

    // Enable dropped mid-measurement for 5 cycles.
    start_phase();
    repeat (4) step(1'b0);
    for (int k = 0; k < 7 * 18; k++) begin
      en = !((k / 18) == 2 && (k % 18) >= 8 && (k % 18) < 13);
      step((k % 18) < 3);
    end
    en = 1'b1;
    end_phase("enable");
    check("en_results", got16.size(), 5);

    // 4-high / 10-low waveform with a 1-cycle glitch in the low phase.
    start_phase();
    repeat (4) step(1'b0);
    repeat (6) begin
      wave(4, 4, 1);
      step(1'b1);
      repeat (5) step(1'b0);
    end
    end_phase("glitch");
`ifdef PULSE_METER_FILTER_EN
    check("glitch_results", got16.size(), 5);
    foreach (got16[k])
      check("glitch_value", {got16[k].p, got16[k].h, got16[k].o}, {32'd14, 32'd4, 1'b0});
`endif

    // Random waveforms with random backpressure.
    start_phase();
    rdy_mode = 2;
    repeat (8) step(1'b0);
    repeat (60) begin
      hi = $urandom_range(1, 12);
      lo = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) lo = $urandom_range(16, 30);
      if ($urandom_range(0, 9) == 0) hi = $urandom_range(16, 24);
      wave(hi, lo, 1);
    end
    rdy_mode = 0;
    wave(3, 5, 4);
    end_phase("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
